// File: rtl/sar_scan_pkg.sv
// Shared types and constants for the SAR multi-channel scan sequencer.
package sar_scan_pkg;

  localparam int unsigned DefWidth         = 6;
  localparam int unsigned DefNumCh         = 4;
  localparam int unsigned DefSettleCycles  = 2;
  localparam int unsigned DefTimeoutCycles = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT_EOC = 3'd4,
    ST_STORE    = 3'd5
  } state_e;

  // Bits needed to encode n values, never less than one.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_next_channel.sv
// Priority finder: lowest set mask bit at an index >= ptr_i.
module sar_next_channel
  import sar_scan_pkg::*;
#(
  parameter int unsigned NumCh = DefNumCh
) (
  input  logic [NumCh-1:0]       mask_i,
  input  logic [ch_w(NumCh):0]   ptr_i,
  output logic                   found_c,
  output logic [ch_w(NumCh)-1:0] ch_c
);

  localparam int unsigned ChW  = ch_w(NumCh);
  localparam int unsigned PtrW = ChW + 1;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found_c = 1'b0;
    ch_c    = '0;
    for (int i = int'(NumCh) - 1; i >= 0; i--) begin
      if (mask_i[i] && (ptr_i <= PtrW'(i))) begin
        found_c = 1'b1;
        ch_c    = ChW'(i);
      end
    end
  end

endmodule

// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan controller around a SAR conversion FSM: mux select,
// start pulse, end-of-conversion wait with timeout, per-channel result file.
module sar_scan_sequencer
  import sar_scan_pkg::*;
#(
  parameter int unsigned Width         = DefWidth,
  parameter int unsigned NumCh         = DefNumCh,
  parameter int unsigned SettleCycles  = DefSettleCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   trigger_i,
  input  logic                   continuous_i,
  input  logic [NumCh-1:0]       ch_mask_i,
  output logic                   sar_start_o,
  input  logic                   sar_eoc_i,
  input  logic [Width-1:0]       sar_result_i,
  output logic [ch_w(NumCh)-1:0] mux_sel_o,
  output logic                   busy_o,
  output logic                   data_valid_o,
  output logic [Width-1:0]       data_o,
  output logic [ch_w(NumCh)-1:0] data_ch_o,
  input  logic [ch_w(NumCh)-1:0] rd_ch_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   timeout_o,
  output logic                   overrun_o
);

  localparam int unsigned ChW     = ch_w(NumCh);
  localparam int unsigned PtrW    = ChW + 1;
  localparam int unsigned SetW    = ch_w(SettleCycles);
  localparam int unsigned TmoW    = ch_w(TimeoutCycles);
  localparam int unsigned RfDepth = 1 << ChW;

  state_e             state_q, state_d;
  logic [NumCh-1:0]   mask_q, mask_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [ChW-1:0]     mux_sel_q, mux_sel_d;
  logic [SetW-1:0]    settle_q, settle_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;
  logic [Width-1:0]   data_q, data_d;
  logic [ChW-1:0]     data_ch_q, data_ch_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;
  logic [Width-1:0]   rf_q [RfDepth];
  logic [Width-1:0]   rf_d [RfDepth];

  logic               nxt_found_c;
  logic [ChW-1:0]     nxt_ch_c;

  sar_next_channel #(
    .NumCh(NumCh)
  ) u_next_channel (
    .mask_i (mask_q),
    .ptr_i  (ptr_q),
    .found_c(nxt_found_c),
    .ch_c   (nxt_ch_c)
  );

  // Next-state and registered-output logic; outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    mux_sel_d = mux_sel_q;
    settle_d  = settle_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    data_ch_d = data_ch_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q | (trigger_i & busy_q);
    rf_d      = rf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && trigger_i && (ch_mask_i != '0)) begin
          state_d = ST_SELECT;
          mask_d  = ch_mask_i;
          ptr_d   = '0;
        end
      end
      ST_SELECT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (nxt_found_c) begin
          mux_sel_d = nxt_ch_c;
          settle_d  = '0;
          state_d   = ST_SETTLE;
        end else if (continuous_i && (ch_mask_i != '0)) begin
          mask_d = ch_mask_i;
          ptr_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (settle_q == SetW'(SettleCycles - 1)) begin
          state_d = ST_START;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      ST_START: begin
        state_d = ST_WAIT_EOC;
        tmo_d   = TmoW'(1);
      end
      ST_WAIT_EOC: begin
        if (sar_eoc_i) begin
          state_d   = ST_STORE;
          data_d    = sar_result_i;
          data_ch_d = mux_sel_q;
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
          timeout_d = 1'b1;
          ptr_d     = PtrW'(mux_sel_q) + PtrW'(1);
          state_d   = enable_i ? ST_SELECT : ST_IDLE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      ST_STORE: begin
        rf_d[data_ch_q] = data_q;
        ptr_d           = PtrW'(data_ch_q) + PtrW'(1);
        state_d         = enable_i ? ST_SELECT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    start_d = (state_d == ST_START);
    valid_d = (state_d == ST_STORE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      ptr_q     <= '0;
      mux_sel_q <= '0;
      settle_q  <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      data_ch_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      mux_sel_q <= mux_sel_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      rf_q      <= rf_d;
    end
  end

  assign sar_start_o  = start_q;
  assign mux_sel_o    = mux_sel_q;
  assign busy_o       = busy_q;
  assign data_valid_o = valid_q;
  assign data_o       = data_q;
  assign data_ch_o    = data_ch_q;
  assign timeout_o    = timeout_q;
  assign overrun_o    = overrun_q;
  // Read port sees the registered file, so a same-cycle write shows next cycle.
  assign rd_data_o    = rf_q[rd_ch_i];

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Self-checking bench for sar_scan_sequencer with a SAR model and result scoreboard.
module tb_sar_scan_sequencer;

  localparam int unsigned Width         = 6;
  localparam int unsigned NumCh         = 4;
  localparam int unsigned SettleCycles  = 2;
  localparam int unsigned TimeoutCycles = 32;
  localparam int          EocDelay      = 8;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             enable_i = 1'b0;
  logic             trigger_i = 1'b0;
  logic             continuous_i = 1'b0;
  logic [3:0]       ch_mask_i = '0;
  logic             sar_start_o;
  logic             sar_eoc_i = 1'b0;
  logic [5:0]       sar_result_i = '0;
  logic [1:0]       mux_sel_o;
  logic             busy_o;
  logic             data_valid_o;
  logic [5:0]       data_o;
  logic [1:0]       data_ch_o;
  logic [1:0]       rd_ch_i = '0;
  logic [5:0]       rd_data_o;
  logic             timeout_o;
  logic             overrun_o;

  sar_scan_sequencer #(
    .Width        (Width),
    .NumCh        (NumCh),
    .SettleCycles (SettleCycles),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .trigger_i   (trigger_i),
    .continuous_i(continuous_i),
    .ch_mask_i   (ch_mask_i),
    .sar_start_o (sar_start_o),
    .sar_eoc_i   (sar_eoc_i),
    .sar_result_i(sar_result_i),
    .mux_sel_o   (mux_sel_o),
    .busy_o      (busy_o),
    .data_valid_o(data_valid_o),
    .data_o      (data_o),
    .data_ch_o   (data_ch_o),
    .rd_ch_i     (rd_ch_i),
    .rd_data_o   (rd_data_o),
    .timeout_o   (timeout_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] ch;
    logic [5:0] val;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    int         starts;
    int         busy;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[5];
  logic [5:0] res_tab[4] = '{6'h2A, 6'h15, 6'h33, 6'h3F};
  logic [5:0] mon_rf[4]  = '{default: '0};
  logic [3:0] sar_dead   = '0;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int n_valid = 0;
  int last_start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch);
    exp_t e;
    e.ch  = 2'(ch);
    e.val = res_tab[ch];
    sb.push_back(e);
  endtask

  // SAR model, start-pulse counter, read-port shadow and result scoreboard.
  task automatic monitor();
    logic       armed = 1'b0;
    logic       prev_start = 1'b0;
    logic [1:0] sar_ch = '0;
    int         start_cyc = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      sar_eoc_i = 1'b0;
      if (armed && (cyc - start_cyc == EocDelay)) begin
        armed = 1'b0;
        if (!sar_dead[sar_ch]) begin
          sar_eoc_i    = 1'b1;
          sar_result_i = res_tab[sar_ch];
        end
      end
      if (sar_start_o) begin
        check("start_one_cycle", int'(prev_start), 0);
        armed          = 1'b1;
        start_cyc      = cyc;
        sar_ch         = mux_sel_o;
        last_start_cyc = cyc;
        n_start++;
      end
      prev_start = sar_start_o;
      check("rd_data", int'(rd_data_o), int'(mon_rf[rd_ch_i]));
      if (data_valid_o) begin
        n_valid++;
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got ch=%0d val=%0h expected no output", data_ch_o, data_o);
        end else begin
          e = sb.pop_front();
          check("data_ch", int'(data_ch_o), int'(e.ch));
          check("data_val", int'(data_o), int'(e.val));
          check("ch_latency", cyc - last_start_cyc, EocDelay + 1);
          mon_rf[e.ch] = e.val;
        end
      end
      if (rst_i) begin
        mon_rf = '{default: '0};
        armed  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    enable_i     = 1'b0;
    trigger_i    = 1'b0;
    continuous_i = 1'b0;
    ch_mask_i    = '0;
    sar_dead     = '0;
    rd_ch_i      = '0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy_o) break;
      step();
    end
    if (i == budget) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_wait: busy_o still 1 after %0d cycles expected 0", budget);
    end
  endtask

  task automatic check_rd(input string name, input int ch, input int exp);
    step();
    rd_ch_i = 2'(ch);
    #1;
    check(name, int'(rd_data_o), exp);
  endtask

  initial begin
    int s0;
    int v0;
    int found;

    do_reset();
    fork
      monitor();
    join_none

    check("rst_busy", int'(busy_o), 0);
    check("rst_start", int'(sar_start_o), 0);
    check("rst_valid", int'(data_valid_o), 0);
    check("rst_mux", int'(mux_sel_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    check("rst_overrun", int'(overrun_o), 0);

    // Single-shot scans: mask, expected start pulses, expected busy after trigger.
    vecs[0] = '{mask: 4'b1011, starts: 3, busy: 1};
    vecs[1] = '{mask: 4'b0001, starts: 1, busy: 1};
    vecs[2] = '{mask: 4'b1000, starts: 1, busy: 1};
    vecs[3] = '{mask: 4'b1111, starts: 4, busy: 1};
    vecs[4] = '{mask: 4'b0000, starts: 0, busy: 0};
    for (int r = 0; r < 5; r++) begin
      do_reset();
      enable_i  = 1'b1;
      ch_mask_i = vecs[r].mask;
      s0        = n_start;
      for (int c = 0; c < 4; c++) if (vecs[r].mask[c]) push(c);
      pulse_trigger();
      ch_mask_i = ~vecs[r].mask;
      check("row_busy", int'(busy_o), vecs[r].busy);
      wait_idle(400);
      check("row_starts", n_start - s0, vecs[r].starts);
      check("row_sb_drained", sb.size(), 0);
      check("row_overrun", int'(overrun_o), 0);
      for (int c = 0; c < 4; c++)
        check_rd("row_rd", c, vecs[r].mask[c] ? int'(res_tab[c]) : 0);
    end

    // Continuous round-robin, continuous_i dropped during the third scan.
    do_reset();
    enable_i     = 1'b1;
    continuous_i = 1'b1;
    ch_mask_i    = 4'b0110;
    s0 = n_start;
    v0 = n_valid;
    repeat (3) begin
      push(1);
      push(2);
    end
    pulse_trigger();
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (n_valid - v0 >= 5) begin
        found = 1;
        break;
      end
      step();
    end
    check("cont_fifth_valid", found, 1);
    continuous_i = 1'b0;
    wait_idle(200);
    check("cont_valids", n_valid - v0, 6);
    check("cont_starts", n_start - s0, 6);
    check("cont_sb_drained", sb.size(), 0);

    // Conversion that never ends: timeout latency and stickiness.
    do_reset();
    enable_i  = 1'b1;
    sar_dead  = 4'b0100;
    ch_mask_i = 4'b0100;
    v0 = n_valid;
    pulse_trigger();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (timeout_o) begin
        found = 1;
        break;
      end
      step();
    end
    check("tmo_seen", found, 1);
    check("tmo_latency", cyc - last_start_cyc, TimeoutCycles);
    wait_idle(50);
    check("tmo_idle", int'(busy_o), 0);
    check("tmo_no_valid", n_valid - v0, 0);
    repeat (20) step();
    check("tmo_sticky", int'(timeout_o), 1);
    do_reset();
    check("tmo_cleared", int'(timeout_o), 0);

    // Trigger while busy sets overrun and is otherwise dropped.
    enable_i  = 1'b1;
    ch_mask_i = 4'b1111;
    for (int c = 0; c < 4; c++) push(c);
    s0 = n_start;
    pulse_trigger();
    repeat (3) step();
    check("ovr_pre", int'(overrun_o), 0);
    pulse_trigger();
    check("ovr_set", int'(overrun_o), 1);
    wait_idle(400);
    check("ovr_starts", n_start - s0, 4);
    check("ovr_sticky", int'(overrun_o), 1);
    check("ovr_sb_drained", sb.size(), 0);

    // enable_i dropped while ch0 converts: ch0 stored, ch1 never started.
    do_reset();
    enable_i  = 1'b1;
    ch_mask_i = 4'b0011;
    push(0);
    s0 = n_start;
    pulse_trigger();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (n_start - s0 >= 1) begin
        found = 1;
        break;
      end
      step();
    end
    check("en_start_seen", found, 1);
    enable_i = 1'b0;
    wait_idle(50);
    check("en_starts", n_start - s0, 1);
    check("en_sb_drained", sb.size(), 0);
    check_rd("en_rd_ch0", 0, int'(res_tab[0]));
    check_rd("en_rd_ch1", 1, 0);
    repeat (5) step();
    check("en_stays_idle", int'(busy_o), 0);

    // Reset asserted during SETTLE after a full scan populated the file.
    do_reset();
    enable_i  = 1'b1;
    ch_mask_i = 4'b1111;
    for (int c = 0; c < 4; c++) push(c);
    pulse_trigger();
    wait_idle(400);
    check_rd("pre_rst_rd_ch3", 3, int'(res_tab[3]));
    s0 = n_start;
    pulse_trigger();
    step();
    check("settle_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    step();
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_start", int'(sar_start_o), 0);
    check("mid_rst_valid", int'(data_valid_o), 0);
    check("mid_rst_mux", int'(mux_sel_o), 0);
    check("mid_rst_data", int'(data_o), 0);
    rst_i = 1'b0;
    repeat (15) step();
    check("mid_rst_no_start", n_start - s0, 0);
    for (int c = 0; c < 4; c++) check_rd("mid_rst_rd", c, 0);

    check("final_sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
